serial_pattern_tx: RTL and testbench
====================================

// Module: serial_pattern_tx
// PURPOSE
//  Transmit side of the single-wire serial pattern link.
//  - Accepts parallel words on a valid/ready handshake and serialises them MSB-first onto w, one bit per clk.
//  - Inserts GAP idle-zero bits after each word.
//  - Runs a bit-exact model of the far-end pattern detector, so software sees the flag the receiver will raise (z_pred) and a count of flagged cycles.
// PARAMETERS
//  WIDTH  8   data bits per word (>=2)
//  GAP    2   idle '0' bits after each word (>=0)
//  CNT_W  16  width of flag_count (saturating)
// PORTS
//  clk         in   1      clock, all logic on posedge
//  reset       in   1      synchronous, active-high
//  in_valid    in   1      word offered
//  in_ready    out  1      block can accept a word this cycle
//  in_data     in   WIDTH  word to send, MSB first
//  w           out  1      serial line, registered
//  busy        out  1      1 while data/parity/gap bits are on w
//  z_pred      out  1      predicted receiver flag, registered
//  flag_count  out  CNT_W  cycles with z_pred=1 since reset, saturates at all-ones
// BEHAVIOUR
//  Reset values: w=0, busy=0, in_ready=0 during reset then 1, z_pred=0, flag_count=0.
//  Reset is honoured mid-word: the word is aborted, the shift register is cleared, and the model returns to state A.
//  TX FSM states: IDLE, DATA, PAR (only with PARITY_EN), GAP.
//  - IDLE: w=0, busy=0, in_ready=1.
//    Accept on in_valid & in_ready at edge T; w = in_data[WIDTH-1] in cycle T+1.
//  - DATA: WIDTH cycles, w = data[WIDTH-1] down to data[0].
//    Then PAR if enabled, else GAP if GAP>0, else IDLE.
//  - GAP: GAP cycles with w=0, then IDLE.
//  - in_ready is also 1 in the final bit cycle of a word (last data, parity or gap bit).
//    An accept there starts the next word's MSB in the following cycle with no bubble.
//  - in_data is sampled only at accept; later changes are ignored.
//  Receiver model (seq_flag_model) samples w each edge; states A..F, reset to A:
//    A: 1->B, 0->A    B: 1->C, 0->D    C: 1->E, 0->D
//    D: 1->F, 0->A    E: 1->E, 0->D    F: 1->C, 0->D
//  - z_pred = (model state == E || model state == F).
//  - A bit on w in cycle k affects z_pred in cycle k+1.
//  - flag_count += 1 on each edge where z_pred=1, unless already all-ones.
//  - The model keeps running in IDLE, sampling w=0.
// CONFIGURATION
//  PARITY_EN defined:
//  - One even-parity bit (XOR of the word) is sent after data[0], before the gap.
//  - A word occupies WIDTH+1+GAP cycles.
//  PARITY_EN undefined:
//  - No PAR state; a word occupies WIDTH+GAP cycles.
// STRUCTURE
//  Package serial_pattern_pkg:
//  - tx_state_t enum {IDLE, DATA, PAR, GAP}.
//  - rx_state_t enum {A, B, C, D, E, F}, encoded 3 bits.
//  - Bit-counter width function clog2-based.
//  Sub-module seq_flag_model:
//  - Ports: clk, reset, w, z.
//  - Holds rx_state_t and drives z_pred.
//  Top holds the handshake, the TX FSM, the shift register, the bit/gap counter and flag_count.
// TESTING
//  1. Hold reset 3 cycles, in_valid=1 -> w=0, busy=0, in_ready=0, z_pred=0, flag_count=0. Nothing is accepted.
//  2. Send 8'hE0 (GAP=2, accept at T):
//     - w = 1,1,1,0,0,0,0,0,0,0 in T+1..T+10.
//     - z_pred=1 only in T+4; flag_count=1.
//     - in_ready=1 again in T+10.
//  3. Send 8'hA0 -> model B,D,F,D,A; z_pred=1 for exactly one cycle (T+4); flag_count increments by 1.
//  4. Send 8'hFF -> z_pred=1 for 6 consecutive cycles (T+4..T+9), then 0 after the first gap bit; flag_count=6.
//  5. GAP=0, in_valid held with two words 8'hFF:
//     - 16 consecutive w=1 with no bubble.
//     - in_ready pulses in the last bit cycle.
//     - z_pred=1 for 14 cycles.
//  6. Assert reset at DATA bit 4 of 8'hF0 -> next cycle w=0, busy=0, z_pred=0, flag_count=0, in_ready=1 after reset.
//     PARITY_EN build: 8'h07 -> 9th bit on w is 1; 8'h03 -> 9th bit is 0.

Source files
------------

// File: rtl/serial_pattern_pkg.sv
// Shared types and helpers for the single-wire serial pattern link.
// Holds the transmitter and receiver-model state encodings and the
// width helper used to size the bit/gap counter.
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        GAP
    } tx_state_t;

    typedef enum logic [2:0] {
        A,
        B,
        C,
        D,
        E,
        F
    } rx_state_t;

    // Counter width needed to count 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_flag_model.sv
// Bit-exact copy of the far-end pattern detector. It samples the serial
// line on every clock edge and raises z while the detector sits in E or F,
// so the transmit side can predict the flag the receiver will report.
module seq_flag_model (
    input  logic clk,
    input  logic reset,
    input  logic w,
    output logic z
);
    import serial_pattern_pkg::*;

    rx_state_t state;
    rx_state_t nxt;

    // Detector transition table: the next state depends on the current state and the line bit
    always_comb begin
        nxt = A;
        case (state)
            A:       nxt = w ? B : A;
            B:       nxt = w ? C : D;
            C:       nxt = w ? E : D;
            D:       nxt = w ? F : A;
            E:       nxt = w ? E : D;
            F:       nxt = w ? C : D;
            default: nxt = A;
        endcase
    end

    // Advance the detector and register the flag straight from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= A;
            z     <= 1'b0;
        end else begin
            state <= nxt;
            z     <= (nxt == E) || (nxt == F);
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Transmit side of the single-wire serial pattern link.
// Words arrive on a valid/ready handshake, go out MSB-first on w one bit per
// clock, and are followed by GAP idle-zero bits. A model of the far-end
// detector predicts the receiver flag (z_pred), and flag_count accumulates
// the number of flagged cycles, saturating at all-ones.
// Build option: define PARITY_EN to append one even-parity bit after data[0].
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             w,
    output logic             busy,
    output logic             z_pred,
    output logic [CNT_W-1:0] flag_count
);
    import serial_pattern_pkg::*;

    localparam int CW = cnt_width((WIDTH > GAP) ? WIDTH : GAP);
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_GAP  = CW'((GAP > 0) ? GAP - 1 : 0);

    tx_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;
`ifdef PARITY_EN
    logic             par_bit;
`endif

    // Flag the final bit cycle of a word so the next word can follow without a bubble
    always_comb begin
        last_bit = 1'b0;
        case (state)
`ifdef PARITY_EN
            PAR:                   last_bit = (GAP == 0);
`else
            DATA:                  last_bit = (cnt == LAST_DATA) && (GAP == 0);
`endif
            serial_pattern_pkg::GAP: last_bit = (cnt == LAST_GAP);
            default:               last_bit = 1'b0;
        endcase
    end

    assign in_ready = !reset && ((state == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;

    // Transmit FSM: loads a word on accept, shifts data out, then parity and gap bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            w       <= 1'b0;
            busy    <= 1'b0;
            shreg   <= '0;
            cnt     <= '0;
`ifdef PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if ((state == IDLE) || last_bit) begin
            if (accept) begin
                state   <= DATA;
                w       <= in_data[WIDTH-1];
                busy    <= 1'b1;
                shreg   <= {in_data[WIDTH-2:0], 1'b0};
                cnt     <= '0;
`ifdef PARITY_EN
                par_bit <= ^in_data;
`endif
            end else begin
                state <= IDLE;
                w     <= 1'b0;
                busy  <= 1'b0;
            end
        end else begin
            case (state)
                DATA: begin
                    if (cnt != LAST_DATA) begin
                        w     <= shreg[WIDTH-1];
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        cnt   <= cnt + CW'(1);
                    end else begin
`ifdef PARITY_EN
                        state <= PAR;
                        w     <= par_bit;
`else
                        state <= serial_pattern_pkg::GAP;
                        w     <= 1'b0;
                        cnt   <= '0;
`endif
                    end
                end
`ifdef PARITY_EN
                PAR: begin
                    state <= serial_pattern_pkg::GAP;
                    w     <= 1'b0;
                    cnt   <= '0;
                end
`endif
                serial_pattern_pkg::GAP: begin
                    cnt <= cnt + CW'(1);
                end
                default: begin
                    state <= IDLE;
                    w     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    seq_flag_model u_model (
        .clk   (clk),
        .reset (reset),
        .w     (w),
        .z     (z_pred)
    );

    // Count flagged cycles, holding at all-ones once saturated
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_count <= '0;
        end else if (z_pred && (flag_count != '1)) begin
            flag_count <= flag_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx: one instance with GAP=2, one with GAP=0.
// Expected line bits are built from the word contents, and the receiver flag
// is predicted from the detector transition table applied to those bits.
module tb_serial_pattern_tx;

    localparam int TB_GAP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_valid0;
    logic        in_ready, in_ready0;
    logic [7:0]  in_data, in_data0;
    logic        w, w0, busy, busy0, z_pred, z_pred0;
    logic [15:0] flag_count, flag_count0;

    int compared   = 0;
    int mismatched = 0;

    // Detector next state indexed [state][bit], states A..F numbered 0..5
    int rx_next [6][2] = '{'{0, 1}, '{3, 2}, '{3, 4}, '{0, 5}, '{3, 4}, '{3, 2}};

    // Reference state for each instance: detector state, flag, count, expected w
    int ms, mc, ms0, mc0;
    bit mz, mw, mz0, mw0;

    logic [7:0] b2b_words[$];

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(8), .GAP(TB_GAP), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .w(w), .busy(busy), .z_pred(z_pred), .flag_count(flag_count)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .w(w0), .busy(busy0), .z_pred(z_pred0), .flag_count(flag_count0)
    );

    task automatic model_edge(inout int s, inout bit zz, inout int cnt, input bit wbit);
        if (zz && cnt != 65535) cnt++;
        s  = rx_next[s][int'(wbit)];
        zz = (s == 4) || (s == 5);
    endtask

    // Every rising edge goes through here so both reference models stay in step
    task automatic tick(input bit nw, input bit nw0);
        @(posedge clk);
        if (reset) begin
            ms = 0; mz = 0; mc = 0; mw = 0;
            ms0 = 0; mz0 = 0; mc0 = 0; mw0 = 0;
        end else begin
            model_edge(ms, mz, mc, mw);
            mw = nw;
            model_edge(ms0, mz0, mc0, mw0);
            mw0 = nw0;
        end
    endtask

    task automatic test_reset();
        logic [19:0] obs, expv;
        reset = 1'b1;
        in_valid = 1'b1;  in_data  = 8'($urandom);
        in_valid0 = 1'b1; in_data0 = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0);
            @(negedge clk);
            obs  = {w, busy, in_ready, z_pred, flag_count};
            expv = 20'h0;
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL reset_hold cyc%0d: got w/busy/rdy/z=%b fc=%0d, want %b fc=%0d",
                         k, obs[19:16], obs[15:0], expv[19:16], expv[15:0]);
            end
            compared++;
            if (in_ready0 !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_ready0 cyc%0d: got %b, want 0", k, in_ready0);
            end
        end
        reset = 1'b0;
        in_valid = 1'b0;
        in_valid0 = 1'b0;
        #1;
        obs  = {w, busy, in_ready, z_pred, flag_count};
        expv = {4'b0010, 16'h0};
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL reset_release: got w/busy/rdy/z=%b fc=%0d, want %b fc=%0d",
                     obs[19:16], obs[15:0], expv[19:16], expv[15:0]);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_single_word(input logic [7:0] word, input int exp_pulses, input string tag);
        bit bits[$];
        int L, c0, pulses;
        logic [19:0] obs, expv;
        bits = {};
        for (int i = 7; i >= 0; i--) bits.push_back(word[i]);
`ifdef PARITY_EN
        bits.push_back(^word);
`endif
        for (int i = 0; i < TB_GAP; i++) bits.push_back(1'b0);
        L = bits.size();
        c0 = mc;
        pulses = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = word;
        tick(bits[0], 1'b0);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        for (int k = 0; k < L + 3; k++) begin
            @(negedge clk);
            obs  = {w, busy, in_ready, z_pred, flag_count};
            expv = {mw, (k < L), (k >= L - 1), mz, 16'(mc)};
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL %s cyc%0d: got w/busy/rdy/z=%b fc=%0d, want %b fc=%0d",
                         tag, k, obs[19:16], obs[15:0], expv[19:16], expv[15:0]);
            end
            if (z_pred === 1'b1) pulses++;
            tick((k + 1 < L) ? bits[k + 1] : 1'b0, 1'b0);
        end
        @(negedge clk);
        if (exp_pulses >= 0) begin
            compared++;
            if (pulses != exp_pulses || flag_count !== 16'(c0 + exp_pulses)) begin
                mismatched++;
                $display("[TB] FAIL %s_pulses: got pulses=%0d fc=%0d, want pulses=%0d fc=%0d",
                         tag, pulses, flag_count, exp_pulses, c0 + exp_pulses);
            end
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back(input int exp_pulses, input string tag);
        bit bits[$];
        int Lw, N, n, acc, c0, pulses;
        logic [19:0] obs, expv;
        bits = {};
        n = b2b_words.size();
        foreach (b2b_words[j]) begin
            for (int i = 7; i >= 0; i--) bits.push_back(b2b_words[j][i]);
`ifdef PARITY_EN
            bits.push_back(^b2b_words[j]);
`endif
        end
        N  = bits.size();
        Lw = N / n;
        c0 = mc0;
        pulses = 0;
        acc = 0;
        @(negedge clk);
        in_valid0 = 1'b1;
        in_data0  = b2b_words[0];
        tick(1'b0, bits[0]);
        #1;
        if (n > 1) in_data0 = b2b_words[1];
        else begin in_valid0 = 1'b0; in_data0 = 8'($urandom); end
        for (int k = 0; k < N + 3; k++) begin
            @(negedge clk);
            obs  = {w0, busy0, in_ready0, z_pred0, flag_count0};
            expv = {mw0, (k < N), ((k % Lw) == Lw - 1) || (k >= N), mz0, 16'(mc0)};
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL %s cyc%0d: got w/busy/rdy/z=%b fc=%0d, want %b fc=%0d",
                         tag, k, obs[19:16], obs[15:0], expv[19:16], expv[15:0]);
            end
            if (z_pred0 === 1'b1) pulses++;
            tick(1'b0, (k + 1 < N) ? bits[k + 1] : 1'b0);
            if (k < N - 1 && (k % Lw) == Lw - 1) begin
                acc++;
                #1;
                if (acc + 1 < n) in_data0 = b2b_words[acc + 1];
                else begin in_valid0 = 1'b0; in_data0 = 8'($urandom); end
            end
        end
        @(negedge clk);
        if (exp_pulses >= 0) begin
            compared++;
            if (pulses != exp_pulses || flag_count0 !== 16'(c0 + exp_pulses)) begin
                mismatched++;
                $display("[TB] FAIL %s_pulses: got pulses=%0d fc=%0d, want pulses=%0d fc=%0d",
                         tag, pulses, flag_count0, exp_pulses, c0 + exp_pulses);
            end
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] word;
        logic [19:0] obs, expv;
        word = 8'hF0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = word;
        tick(word[7], 1'b0);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            obs  = {w, busy, in_ready, z_pred, flag_count};
            expv = {mw, 1'b1, 1'b0, mz, 16'(mc)};
            compared++;
            if (obs !== expv) begin
                mismatched++;
                $display("[TB] FAIL midreset_pre cyc%0d: got w/busy/rdy/z=%b fc=%0d, want %b fc=%0d",
                         k, obs[19:16], obs[15:0], expv[19:16], expv[15:0]);
            end
            if (k == 4) reset = 1'b1;
            tick(word[6 - k], 1'b0);
        end
        @(negedge clk);
        obs  = {w, busy, in_ready, z_pred, flag_count};
        expv = 20'h0;
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL midreset_abort: got w/busy/rdy/z=%b fc=%0d, want %b fc=%0d",
                     obs[19:16], obs[15:0], expv[19:16], expv[15:0]);
        end
        reset = 1'b0;
        #1;
        obs  = {w, busy, in_ready, z_pred, flag_count};
        expv = {4'b0010, 16'h0};
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL midreset_release: got w/busy/rdy/z=%b fc=%0d, want %b fc=%0d",
                     obs[19:16], obs[15:0], expv[19:16], expv[15:0]);
        end
        tick(1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] serial_pattern_tx bench start");
        test_reset();
        test_single_word(8'hE0, 1, "word_E0");
        test_single_word(8'hA0, 1, "word_A0");
        test_single_word(8'hFF, 6, "word_FF");
        test_single_word(8'h07, -1, "word_07");
        test_single_word(8'h03, -1, "word_03");
        for (int r = 0; r < 6; r++) begin
            test_single_word(8'($urandom), -1, "word_rand");
        end
        b2b_words = {8'hFF, 8'hFF};
`ifdef PARITY_EN
        test_back_to_back(-1, "b2b_FFFF");
`else
        test_back_to_back(14, "b2b_FFFF");
`endif
        b2b_words = {8'($urandom), 8'($urandom), 8'($urandom)};
        test_back_to_back(-1, "b2b_rand");
        test_reset_mid_word();
        test_single_word(8'hE0, 1, "word_after_reset");
        test_single_word(8'($urandom), -1, "word_rand_end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
